alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; all requirements below use WIDTH=32.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for the registered outputs.
REQ-004 Port: reset_n  input  1  synchronous active-low reset.
REQ-005 Port: srca  input  WIDTH  operand A.
REQ-006 Port: srcb  input  WIDTH  operand B.
REQ-007 Port: alucontrol  input  3  operation select.
REQ-008 Port: aluresult  output  WIDTH  combinational result.
REQ-009 Port: zero  output  1  combinational flag, 1 when aluresult is all zeros.
REQ-010 Port: aluresult_q  output  WIDTH  aluresult registered on clk.
REQ-011 Port: zero_q  output  1  zero registered on clk.
REQ-012 The port order SHALL be srca, srcb, alucontrol, aluresult, zero, clk, reset_n, aluresult_q, zero_q.
- Positional instantiation of the first five ports therefore works unchanged.

Function
REQ-013 aluresult and zero SHALL be purely combinational, with zero latency from srca/srcb/alucontrol and no dependence on clk or reset_n.
REQ-014 alucontrol=000 SHALL give aluresult = srca AND srcb (bitwise).
REQ-015 alucontrol=001 SHALL give aluresult = srca OR srcb (bitwise).
REQ-016 alucontrol=010 SHALL give aluresult = srca + srcb, modulo 2^WIDTH, with the carry-out discarded.
REQ-017 alucontrol=011 SHALL give aluresult = srcb (pass B); srca is ignored.
REQ-018 alucontrol=110 SHALL give aluresult = srca - srcb, modulo 2^WIDTH, in two's complement.
REQ-019 alucontrol=111 SHALL give aluresult = 1 when srca < srcb as signed two's-complement values, else 0; upper WIDTH-1 bits are 0.
REQ-020 SLT SHALL be correct on subtraction overflow, i.e. use (diff sign XOR signed overflow), e.g. srca=0x80000000, srcb=1 gives 1.
REQ-021 alucontrol=100 and alucontrol=101 are reserved and SHALL give aluresult = 0, so zero = 1.
REQ-022 zero SHALL equal 1 exactly when all WIDTH bits of aluresult are 0, for every alucontrol value.
REQ-023 Outputs SHALL never be X or Z for known inputs; no latches.
REQ-024 On each rising clk edge with reset_n=1, aluresult_q SHALL load aluresult and zero_q SHALL load zero.
- Latency is 1 cycle, updated every cycle, with no enable.

Reset
REQ-025 On a rising clk edge with reset_n=0, aluresult_q SHALL become 0 and zero_q SHALL become 1, consistent with a zero result.
REQ-026 reset_n SHALL NOT affect aluresult or zero.
REQ-027 Reset asserted mid-operation SHALL take priority at that edge; the registered outputs SHALL resume tracking on the first edge with reset_n=1.
REQ-028 Before the first clk edge, aluresult_q and zero_q are undefined.

Verification
REQ-029 Case SLT/ADD: srca=-24, srcb=285, alucontrol=111 -> aluresult=1; srca=25, srcb=21, alucontrol=010 -> aluresult=46.
REQ-030 Case SUB: srca=11, srcb=42, alucontrol=110 -> aluresult=0xFFFFFFE1 (-31), zero=0.
- Then srca=5, srcb=5, alucontrol=110 -> aluresult=0, zero=1.
REQ-031 Case logic: srca=0xF0, srcb=0xC3, alucontrol=000 -> aluresult=0xC0.
- srca=0xCC, srcb=0xCA, alucontrol=001 -> aluresult=0xCE.
- srca=0xFF, srcb=0x0A, alucontrol=011 -> aluresult=0x0A.
REQ-032 Case boundaries, each with alucontrol as stated:
- ADD 0xFFFFFFFF + 1 -> aluresult=0, zero=1.
- SLT 0x80000000 vs 1 -> 1.
- SLT 0x7FFFFFFF vs 0x80000000 -> 0.
- alucontrol=101 -> aluresult=0, zero=1.
REQ-033 Case registered path: hold reset_n=0 for one edge -> aluresult_q=0, zero_q=1.
- Release reset_n, apply ADD 25+21 -> aluresult_q=46 and zero_q=0 after the next edge.
REQ-034 Case mid-operation reset: assert reset_n=0 while operands are changing -> aluresult_q=0, zero_q=1 at that edge, while aluresult keeps following the inputs combinationally.

Source files
------------

// File: rtl/alu_if.sv
// ALU operand/result bundle: operands and operation select flow from the
// master to the slave, combinational result and zero flag flow back.
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] aluresult;
  logic             zero;

  modport master (
    output srca,
    output srcb,
    output alucontrol,
    input  aluresult,
    input  zero
  );

  modport slave (
    input  srca,
    input  srcb,
    input  alucontrol,
    output aluresult,
    output zero
  );
endinterface

// File: rtl/alu.sv
// Single-cycle ALU: AND, OR, ADD, pass-B, SUB and signed set-less-than.
// The result and zero flag are combinational. A registered copy of both
// is also provided, and a synchronous active-low reset clears that copy to
// a zero result.

// Combinational datapath, attached to the operand bundle as its slave.
module alu_comb #(
  parameter int WIDTH = 32
) (
  alu_if.slave bus
);
  logic [WIDTH-1:0] diff;
  logic             overflow;
  logic             less;

  // The subtractor feeds both SUB and SLT. SLT takes the sign of the
  // difference and corrects it on signed overflow. Without that
  // correction, 0x80000000 < 1 would give the wrong answer.
  always_comb begin
    diff     = bus.srca - bus.srcb;
    overflow = (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]) &
               (diff[WIDTH-1] ^ bus.srca[WIDTH-1]);
    less     = diff[WIDTH-1] ^ overflow;
  end

  // Operation select. The reserved codes 100 and 101 give a zero result.
  always_comb begin
    bus.aluresult = '0;
    case (bus.alucontrol)
      3'b000:  bus.aluresult = bus.srca & bus.srcb;
      3'b001:  bus.aluresult = bus.srca | bus.srcb;
      3'b010:  bus.aluresult = bus.srca + bus.srcb;
      3'b011:  bus.aluresult = bus.srcb;
      3'b110:  bus.aluresult = diff;
      3'b111:  bus.aluresult = {{(WIDTH-1){1'b0}}, less};
      default: bus.aluresult = '0;
    endcase
  end

  // The zero flag is derived from the final result, so it holds for every opcode.
  always_comb begin
    bus.zero = ~|bus.aluresult;
  end
endmodule

// Top level. The flat port order keeps positional instantiation of the
// first five ports compatible with the purely combinational ALU.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] aluresult,
  output logic             zero,
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] aluresult_q,
  output logic             zero_q
);
  alu_if #(.WIDTH(WIDTH)) bus ();

  assign bus.srca       = srca;
  assign bus.srcb       = srcb;
  assign bus.alucontrol = alucontrol;
  assign aluresult      = bus.aluresult;
  assign zero           = bus.zero;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .bus(bus)
  );

  // Register the result every cycle. Reset loads a zero result with its
  // flag set, and it takes priority at the edge where it is asserted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      aluresult_q <= '0;
      zero_q      <= 1'b1;
    end else begin
      aluresult_q <= aluresult;
      zero_q      <= zero;
    end
  end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the ALU.
// The combinational outputs are checked right after the inputs are driven.
// The expected registered values go into a scoreboard queue and are popped
// once the clock edge has loaded them.
module tb_alu;
  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z;
    string            tag;
  } exp_t;

  logic clk;
  logic reset_n;
  logic [WIDTH-1:0] aluresult_q;
  logic zero_q;

  int total = 0;
  int bad   = 0;
  exp_t scoreboard[$];

  alu_if #(.WIDTH(WIDTH)) bus ();

  alu #(.WIDTH(WIDTH)) dut (
    .srca       (bus.srca),
    .srcb       (bus.srcb),
    .alucontrol (bus.alucontrol),
    .aluresult  (bus.aluresult),
    .zero       (bus.zero),
    .clk        (clk),
    .reset_n    (reset_n),
    .aluresult_q(aluresult_q),
    .zero_q     (zero_q)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, written independently of the RTL (uses a signed compare).
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0] ctl);
    logic [WIDTH-1:0] r;
    case (ctl)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b011:  r = b;
      3'b110:  r = a - b;
      3'b111:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [WIDTH-1:0] obs,
                              input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one step and check the combinational outputs. Queue the expected
  // registered value, then move to the next falling edge and check it.
  task automatic apply_stimulus(input string tag, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [2:0] ctl,
                                input logic rstn, input logic [WIDTH-1:0] exp);
    exp_t e;
    exp_t got;
    bus.srca       = a;
    bus.srcb       = b;
    bus.alucontrol = ctl;
    reset_n        = rstn;
    #1;
    check_output({tag, ".res"}, bus.aluresult, exp);
    check_output({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, exp == '0});
    e.tag = tag;
    e.res = rstn ? exp : '0;
    e.z   = rstn ? (exp == '0) : 1'b1;
    scoreboard.push_back(e);
    @(negedge clk);
    got = scoreboard.pop_front();
    check_output({got.tag, ".res_q"}, aluresult_q, got.res);
    check_output({got.tag, ".zero_q"}, {31'b0, zero_q}, {31'b0, got.z});
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [2:0]       rc;

    // Hold reset for one edge. The combinational path still follows the inputs.
    apply_stimulus("reset",    32'd25, 32'd21, 3'b010, 1'b0, 32'd46);
    apply_stimulus("add",      32'd25, 32'd21, 3'b010, 1'b1, 32'd46);
    apply_stimulus("slt_neg",  -32'sd24, 32'd285, 3'b111, 1'b1, 32'd1);
    apply_stimulus("sub_neg",  32'd11, 32'd42, 3'b110, 1'b1, 32'hFFFF_FFE1);
    apply_stimulus("sub_zero", 32'd5, 32'd5, 3'b110, 1'b1, 32'd0);
    apply_stimulus("and",      32'hF0, 32'hC3, 3'b000, 1'b1, 32'hC0);
    apply_stimulus("or",       32'hCC, 32'hCA, 3'b001, 1'b1, 32'hCE);
    apply_stimulus("passb",    32'hFF, 32'h0A, 3'b011, 1'b1, 32'h0A);
    apply_stimulus("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'b010, 1'b1, 32'd0);
    apply_stimulus("slt_ovf",  32'h8000_0000, 32'd1, 3'b111, 1'b1, 32'd1);
    apply_stimulus("slt_max",  32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 1'b1, 32'd0);
    apply_stimulus("rsv101",   32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 1'b1, 32'd0);
    apply_stimulus("rsv100",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 1'b1, 32'd0);
    apply_stimulus("slt_false", 32'd7, 32'd3, 3'b111, 1'b1, 32'd0);

    // Assert reset while the operands change. Recovery happens on the first released edge.
    apply_stimulus("midrst_a", 32'd7, 32'd3, 3'b110, 1'b0, 32'd4);
    apply_stimulus("midrst_b", 32'd9, 32'd1, 3'b010, 1'b0, 32'd10);
    apply_stimulus("resume",   32'd2, 32'd3, 3'b001, 1'b1, 32'd3);

    // A few random operands for each opcode, checked against the model.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      rc = 3'(i % 8);
      apply_stimulus($sformatf("rand%0d", i), ra, rb, rc, 1'b1, model(ra, rb, rc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
